// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one dbus transaction per load/store,
// with lane alignment and load extension. Option: MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regM_i_valid,
  input  logic                 regM_i_mem_ren,
  input  logic                 regM_i_mem_wen,
  input  logic [1:0]           regM_i_mem_size,
  input  logic                 regM_i_mem_unsigned,
  input  logic [XLEN-1:0]      regM_i_alu_result,
  input  logic [XLEN-1:0]      regM_i_store_data,
  input  logic                 pipe_hold,
  output logic                 dbus_req_valid,
  input  logic                 dbus_req_ready,
  output logic [XLEN-1:0]      dbus_req_addr,
  output logic                 dbus_req_wen,
  output logic [XLEN-1:0]      dbus_req_wdata,
  output logic [BUS_BYTES-1:0] dbus_req_wstrb,
  input  logic                 dbus_rsp_valid,
  input  logic [XLEN-1:0]      dbus_rsp_rdata,
  output logic [XLEN-1:0]      memory_o_memdata,
  output logic                 memory_o_stall,
  output logic                 memory_o_misalign
);

  typedef enum logic [1:0] {
    IDLE, REQ, RESP, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN-1:0]      md_q, md_d;
  logic [BUS_BYTES-1:0] wstrb_q, wstrb_d;
  logic [1:0]           size_q, size_d;
  logic                 wen_q, wen_d;
  logic                 uns_q, uns_d;
  logic                 mis_q, mis_d;
  logic                 acc, is_st;
  logic [BUS_BYTES-1:0] strb_base;
  logic [XLEN-1:0]      rsh, ext;

  assign acc   = regM_i_valid &
                 (regM_i_mem_ren | regM_i_mem_wen);
  assign is_st = regM_i_mem_wen & ~regM_i_mem_ren;
  assign rsh   = dbus_rsp_rdata >> {addr_q[2:0], 3'b000};

  // Unshifted byte-enable pattern for the requested access size
  always_comb begin
    strb_base = 8'h01;
    unique case (regM_i_mem_size)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Sign/zero extension of the lane-aligned load data
  always_comb begin
    ext = rsh;
    unique case (size_q)
      2'd0: ext = uns_q ? {56'b0, rsh[7:0]}
                        : {{56{rsh[7]}}, rsh[7:0]};
      2'd1: ext = uns_q ? {48'b0, rsh[15:0]}
                        : {{48{rsh[15]}}, rsh[15:0]};
      2'd2: ext = uns_q ? {32'b0, rsh[31:0]}
                        : {{32{rsh[31]}}, rsh[31:0]};
      default: ext = rsh;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal;

  // Address not a multiple of the access size
  always_comb begin
    misal = 1'b0;
    unique case (regM_i_mem_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = regM_i_alu_result[0];
      2'd2:    misal = |regM_i_alu_result[1:0];
      default: misal = |regM_i_alu_result[2:0];
    endcase
  end
`endif

  // Next-state and datapath latch decisions
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    md_d    = md_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = regM_i_alu_result;
          wen_d   = is_st;
          size_d  = regM_i_mem_size;
          uns_d   = regM_i_mem_unsigned;
          wdata_d = regM_i_store_data <<
                    {regM_i_alu_result[2:0], 3'b000};
          wstrb_d = strb_base << regM_i_alu_result[2:0];
          state_d = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misal) begin
            state_d = DONE;
            mis_d   = 1'b1;
            md_d    = '0;
          end
`endif
        end
      end
      REQ: begin
        if (dbus_req_ready) state_d = RESP;
      end
      RESP: begin
        if (dbus_rsp_valid) begin
          md_d    = wen_q ? '0 : ext;
          state_d = DONE;
        end
      end
      default: begin
        if (!pipe_hold) begin
          state_d = IDLE;
          mis_d   = 1'b0;
        end
      end
    endcase
  end

  // State and latched access registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      md_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      md_q    <= md_d;
      mis_q   <= mis_d;
    end
  end

  assign dbus_req_valid    = (state_q == REQ);
  assign dbus_req_addr     = {addr_q[XLEN-1:3], 3'b000};
  assign dbus_req_wen      = wen_q;
  assign dbus_req_wdata    = wdata_q;
  assign dbus_req_wstrb    = wstrb_q;
  assign memory_o_memdata  = md_q;
  assign memory_o_misalign = mis_q;
  assign memory_o_stall    = acc & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit
// against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regM_i_valid = 1'b0;
  logic        regM_i_mem_ren = 1'b0;
  logic        regM_i_mem_wen = 1'b0;
  logic [1:0]  regM_i_mem_size = 2'd0;
  logic        regM_i_mem_unsigned = 1'b0;
  logic [63:0] regM_i_alu_result = '0;
  logic [63:0] regM_i_store_data = '0;
  logic        pipe_hold = 1'b0;
  logic        dbus_req_valid;
  logic        dbus_req_ready = 1'b0;
  logic [63:0] dbus_req_addr;
  logic        dbus_req_wen;
  logic [63:0] dbus_req_wdata;
  logic [7:0]  dbus_req_wstrb;
  logic        dbus_rsp_valid = 1'b0;
  logic [63:0] dbus_rsp_rdata = '0;
  logic [63:0] memory_o_memdata;
  logic        memory_o_stall;
  logic        memory_o_misalign;

  int errs = 0;
  int checks = 0;
  logic [63:0] last_md = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .regM_i_valid        (regM_i_valid),
    .regM_i_mem_ren      (regM_i_mem_ren),
    .regM_i_mem_wen      (regM_i_mem_wen),
    .regM_i_mem_size     (regM_i_mem_size),
    .regM_i_mem_unsigned (regM_i_mem_unsigned),
    .regM_i_alu_result   (regM_i_alu_result),
    .regM_i_store_data   (regM_i_store_data),
    .pipe_hold           (pipe_hold),
    .dbus_req_valid      (dbus_req_valid),
    .dbus_req_ready      (dbus_req_ready),
    .dbus_req_addr       (dbus_req_addr),
    .dbus_req_wen        (dbus_req_wen),
    .dbus_req_wdata      (dbus_req_wdata),
    .dbus_req_wstrb      (dbus_req_wstrb),
    .dbus_rsp_valid      (dbus_rsp_valid),
    .dbus_rsp_rdata      (dbus_rsp_rdata),
    .memory_o_memdata    (memory_o_memdata),
    .memory_o_stall      (memory_o_stall),
    .memory_o_misalign   (memory_o_misalign)
  );

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic m_mis(input logic [1:0] s,
                                 input logic [63:0] a);
    return (a % 64'(nbytes(s))) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [1:0] s,
                                        input logic [63:0] a);
    logic [7:0] r;
    int o;
    r = '0;
    o = int'(a % 8);
    for (int i = 0; i < nbytes(s); i++)
      if (o + i < 8) r[o+i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a,
                                          input logic [63:0] d);
    logic [63:0] r;
    int o;
    r = '0;
    o = int'(a % 8);
    for (int i = 0; i < 8; i++)
      if (o + i < 8) r[8*(o+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] s,
                                         input logic u,
                                         input logic [63:0] a,
                                         input logic [63:0] rd);
    logic [63:0] v;
    logic sb;
    int o, n;
    v = '0;
    o = int'(a % 8);
    n = nbytes(s);
    for (int i = 0; i < 8; i++)
      if (o + i < 8) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (n < 8) begin
      sb = v[8*n-1];
      for (int b = 8 * n; b < 64; b++) v[b] = u ? 1'b0 : sb;
    end
    return v;
  endfunction

  task automatic access(input logic ren, input logic wen,
                        input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] sd,
                        input logic [63:0] rd, input int rdy_dly,
                        input int rsp_dly, input int hold,
                        input logic junk);
    logic trap;
    logic [63:0] exp_md;
    int cnt;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = m_mis(sz, a);
`endif
    exp_md = (trap || !ren) ? 64'h0 : m_load(sz, uns, a, rd);
    @(negedge clk);
    regM_i_valid = 1'b1;
    regM_i_mem_ren = ren;
    regM_i_mem_wen = wen;
    regM_i_mem_size = sz;
    regM_i_mem_unsigned = uns;
    regM_i_alu_result = a;
    regM_i_store_data = sd;
    dbus_req_ready = 1'b0;
    dbus_rsp_valid = junk;
    dbus_rsp_rdata = {$urandom, $urandom};
    #1;
    checks++;
    if (memory_o_stall !== 1'b1 || dbus_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL idle: stall=%b valid=%b, want 1 0",
               memory_o_stall, dbus_req_valid);
    end
    if (!trap) begin
      cnt = 0;
      forever begin
        @(negedge clk);
        dbus_req_ready = (cnt >= rdy_dly);
        dbus_rsp_valid = junk;
        dbus_rsp_rdata = {$urandom, $urandom};
        #1;
        checks++;
        if (dbus_req_valid !== 1'b1 || memory_o_stall !== 1'b1 ||
            dbus_req_addr !== {a[63:3], 3'b000} ||
            dbus_req_wen !== (wen & ~ren) ||
            dbus_req_wstrb !== m_strb(sz, a) ||
            dbus_req_wdata !== m_wdata(a, sd)) begin
          errs++;
          $display("FAIL req: v=%b st=%b a=%h w=%b s=%h d=%h want a=%h w=%b s=%h d=%h",
                   dbus_req_valid, memory_o_stall, dbus_req_addr,
                   dbus_req_wen, dbus_req_wstrb, dbus_req_wdata,
                   {a[63:3], 3'b000}, wen & ~ren, m_strb(sz, a),
                   m_wdata(a, sd));
        end
        if (dbus_req_ready) break;
        cnt++;
      end
      for (int i = 0; i <= rsp_dly; i++) begin
        @(negedge clk);
        dbus_req_ready = 1'($urandom);
        dbus_rsp_valid = (i == rsp_dly);
        dbus_rsp_rdata = (i == rsp_dly) ? rd : {$urandom, $urandom};
        #1;
        checks++;
        if (dbus_req_valid !== 1'b0 || memory_o_stall !== 1'b1) begin
          errs++;
          $display("FAIL resp: valid=%b stall=%b, want 0 1",
                   dbus_req_valid, memory_o_stall);
        end
      end
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = junk;
      dbus_rsp_rdata = {$urandom, $urandom};
      pipe_hold = (i < hold);
      #1;
      checks++;
      if (memory_o_stall !== 1'b0 || dbus_req_valid !== 1'b0 ||
          memory_o_memdata !== exp_md ||
          memory_o_misalign !== trap) begin
        errs++;
        $display("FAIL done: st=%b v=%b md=%h mis=%b want 0 0 %h %b",
                 memory_o_stall, dbus_req_valid, memory_o_memdata,
                 memory_o_misalign, exp_md, trap);
      end
    end
    pipe_hold = 1'b0;
    dbus_rsp_valid = 1'b0;
    last_md = exp_md;
  endtask

  task automatic nonmem(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      regM_i_valid = 1'($urandom);
      regM_i_mem_ren = ~regM_i_valid;
      regM_i_mem_wen = 1'b0;
      dbus_rsp_valid = 1'($urandom);
      dbus_req_ready = 1'($urandom);
      #1;
      checks++;
      if (memory_o_stall !== 1'b0 || dbus_req_valid !== 1'b0 ||
          memory_o_memdata !== last_md ||
          memory_o_misalign !== 1'b0) begin
        errs++;
        $display("FAIL nonmem: st=%b v=%b md=%h mis=%b want 0 0 %h 0",
                 memory_o_stall, dbus_req_valid,
                 memory_o_memdata, memory_o_misalign, last_md);
      end
    end
    dbus_rsp_valid = 1'b0;
    dbus_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dbus_req_valid !== 1'b0 || dbus_req_addr !== 64'h0 ||
        dbus_req_wen !== 1'b0 || dbus_req_wdata !== 64'h0 ||
        dbus_req_wstrb !== 8'h0 || memory_o_memdata !== 64'h0 ||
        memory_o_misalign !== 1'b0 || memory_o_stall !== 1'b0) begin
      errs++;
      $display("FAIL reset: v=%b a=%h w=%b d=%h s=%h md=%h mis=%b st=%b",
               dbus_req_valid, dbus_req_addr, dbus_req_wen,
               dbus_req_wdata, dbus_req_wstrb, memory_o_memdata,
               memory_o_misalign, memory_o_stall);
    end
    rst = 1'b1;
  endtask

  task automatic test_load;
    access(1, 0, 0, 0, 64'h1003, 64'h0, 64'h00000000_80000000,
           0, 0, 0, 0);
    checks++;
    if (memory_o_memdata !== 64'hFFFFFFFF_FFFFFF80) begin
      errs++;
      $display("FAIL lb: md=%h want ffffffffffffff80", memory_o_memdata);
    end
    access(1, 0, 0, 1, 64'h1003, 64'h0, 64'h00000000_80000000,
           0, 0, 0, 0);
    checks++;
    if (memory_o_memdata !== 64'h80) begin
      errs++;
      $display("FAIL lbu: md=%h want 80", memory_o_memdata);
    end
  endtask

  task automatic test_store;
    access(0, 1, 2, 0, 64'h2004, 64'h12345678, 64'hDEADBEEF_CAFEF00D,
           0, 0, 0, 0);
    access(1, 1, 1, 0, 64'h2006, 64'hAAAA, 64'h8001_0000_0000_0000,
           0, 1, 0, 0);
    access(0, 1, 3, 0, 64'h2005, 64'h01020304_05060708,
           64'h0, 1, 1, 0, 1);
  endtask

  task automatic test_stall;
    access(1, 0, 3, 0, 64'h5000, 64'h0, 64'h01234567_89ABCDEF,
           5, 3, 0, 1);
    access(0, 1, 0, 0, 64'h5007, 64'h0000_00FE, 64'h0, 2, 2, 0, 1);
  endtask

  task automatic test_hold;
    access(1, 0, 2, 1, 64'h6004, 64'h0, 64'h9ABCDEF0_00000000,
           0, 0, 2, 1);
    nonmem(3);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    regM_i_valid = 1'b1;
    regM_i_mem_ren = 1'b1;
    regM_i_mem_wen = 1'b0;
    regM_i_mem_size = 2'd2;
    regM_i_alu_result = 64'h4000;
    @(negedge clk);
    dbus_req_ready = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (dbus_req_valid !== 1'b0 || memory_o_memdata !== 64'h0 ||
        dbus_req_addr !== 64'h0 || dbus_req_wstrb !== 8'h0) begin
      errs++;
      $display("FAIL rst_mid: v=%b md=%h a=%h s=%h want 0 0 0 0",
               dbus_req_valid, memory_o_memdata, dbus_req_addr,
               dbus_req_wstrb);
    end
    regM_i_valid = 1'b0;
    #1;
    checks++;
    if (memory_o_stall !== 1'b0) begin
      errs++;
      $display("FAIL rst_stall: stall=%b want 0", memory_o_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    dbus_rsp_valid = 1'b1;
    dbus_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dbus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (memory_o_memdata !== 64'h0 || dbus_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL late_rsp: md=%h v=%b want 0 0",
               memory_o_memdata, dbus_req_valid);
    end
    last_md = '0;
    access(1, 0, 2, 0, 64'h4004, 64'h0, 64'h87654321_00000000,
           0, 0, 0, 0);
  endtask

  task automatic test_misalign;
    access(1, 0, 1, 0, 64'h3001, 64'h0, 64'h00000000_0000CD00,
           0, 0, 1, 0);
    access(0, 1, 2, 0, 64'h3006, 64'hCAFEBABE, 64'h0, 1, 0, 0, 0);
    nonmem(2);
  endtask

  task automatic test_random;
    logic r, w;
    for (int k = 0; k < 150; k++) begin
      r = 1'($urandom);
      w = r ? 1'($urandom) : 1'b1;
      access(r, w, 2'($urandom), 1'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2),
             1'($urandom));
      if ($urandom_range(0, 3) == 0) nonmem(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_stall();
    test_hold();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit between the EX/MEM register and the MEM/WB register. It takes the memory operation latched in the EX/MEM register, performs one data-bus transaction with a valid/ready request and a response-valid return, and aligns and extends load data. It produces the load-data word that the MEM/WB register samples. While an access is outstanding it raises a stall, so the EX/MEM register holds and the MEM/WB register bubbles.

Parameters:
XLEN, 64, data/address width; only 64 supported
BUS_BYTES, 8, bus data width in bytes; wstrb width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
regM_i_valid  in  1  EX/MEM slot holds a real instruction
regM_i_mem_ren  in  1  load
regM_i_mem_wen  in  1  store
regM_i_mem_size  in  2  0=byte 1=half 2=word 3=dword
regM_i_mem_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
regM_i_alu_result  in  64  effective address
regM_i_store_data  in  64  store data, right-justified
pipe_hold  in  1  downstream hold (regW_stall); freezes DONE
dbus_req_valid  out  1  request valid
dbus_req_ready  in  1  bus accepts request
dbus_req_addr  out  64  address, low 3 bits cleared
dbus_req_wen  out  1  1=write
dbus_req_wdata  out  64  lane-shifted store data
dbus_req_wstrb  out  8  byte enables
dbus_rsp_valid  in  1  response/ack, one cycle
dbus_rsp_rdata  in  64  aligned doubleword read data
memory_o_memdata  out  64  extended load result (to MEM/WB register)
memory_o_stall  out  1  hold EX/MEM, bubble MEM/WB
memory_o_misalign  out  1  misaligned-access flag

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset (rst=0, async): state=IDLE, all request outputs 0, memdata=0, misalign=0.
- acc = regM_i_valid & (ren | wen); ren and wen both set is treated as a load.
- memory_o_stall = acc & (state != DONE), combinational. Non-memory instructions pass with stall=0 and memdata unchanged.
- IDLE: if acc, latch addr, wen, size, unsigned, and the shifted wdata/wstrb; go to REQ. No bus output in this cycle.
- REQ: dbus_req_valid=1; addr, wen, wdata and wstrb stay stable until dbus_req_ready; on ready go to RESP and drop valid in the next cycle.
- RESP: wait for dbus_rsp_valid. On a load, memdata_q <= ext(rdata >> 8*addr[2:0]). On a store, memdata_q <= 0. Then go to DONE.
- A rsp_valid arriving in the same cycle as ready is not accepted; the response is earliest one cycle after acceptance.
- DONE: stall=0, so EX/MEM advances and MEM/WB samples memory_o_memdata. If pipe_hold=1, stay in DONE; otherwise go to IDLE.
- Minimum access latency: 4 cycles from acc to release (IDLE, REQ with ready=1, RESP with rsp_valid=1, DONE).
- Store lanes: wdata = store_data << 8*off; wstrb = {1,3,F,FF}[size] << off. Bits shifted beyond 8 lanes are dropped.
- Extension: byte/half/word sign-extend from bit 7/15/31, or zero-extend if unsigned. Dword is passed through.
- memory_o_memdata = memdata_q, registered, held until the next load/store completes.
- Reset mid-transaction: abort immediately; a late rsp_valid after reset while in IDLE is ignored.
- rsp_valid in IDLE, REQ or DONE is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: in IDLE, if acc and the address is not a multiple of the access size, no bus request is issued. The FSM goes to DONE with memory_o_misalign=1 (registered, held for the DONE cycles) and memdata_q=0. misalign clears on leaving DONE.
- Undefined: misaligned accesses are issued as-is; lanes crossing the doubleword are truncated; memory_o_misalign is tied 0.

Test Plan:
- lb at 0x1003, rdata=0x00000000_80000000, ready and rsp immediate -> req_addr=0x1000, stall high 3 cycles, memdata=0xFFFFFFFF_FFFFFF80; lbu -> 0x80.
- sw data=0x12345678 at 0x2004 -> wdata=0x12345678_00000000, wstrb=0xF0, wen=1, memdata=0 after ack.
- ready low 5 cycles, then rsp after 3 cycles -> req fields stable throughout, stall held until DONE, single request issued.
- Reset pulse (rst=0) while in RESP -> outputs reset immediately; subsequent rsp_valid ignored; next lw completes normally.
- pipe_hold=1 for 2 cycles in DONE -> state stays DONE, stall=0, memdata stable; non-memory instruction afterward -> stall=0, no bus request.
- With MEM_MISALIGN_TRAP_EN, lh at 0x3001 -> no dbus_req_valid, misalign=1 in DONE; without it, request issued with wstrb/lanes at offset 1.
